// File: rtl/time_to_count_if.sv
// rtl/time_to_count_if.sv - start/busy/done handshake bundle for the BCD MM:SS to seconds converter
interface time_to_count_if #(
    parameter int COUNT_W = 12
);
    logic               start;
    logic [15:0]        time_in;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] count_out;
    logic               bcd_err;
    logic               ovf;

    modport master (
        output start, time_in,
        input  busy, done, count_out, bcd_err, ovf
    );

    modport slave (
        input  start, time_in,
        output busy, done, count_out, bcd_err, ovf
    );
endinterface

// File: rtl/time_to_count.sv
// rtl/time_to_count.sv - validates a BCD MM:SS entry and folds it into binary seconds, one digit per cycle
module time_to_count #(
    parameter int COUNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    time_to_count_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [13:0] MAX_CNT = 14'((14'd1 << COUNT_W) - 14'd1);

    state_t             state_q, state_d;
    logic [15:0]        tin_q, tin_d;
    logic [12:0]        acc_q, acc_d;
    logic [1:0]         idx_q, idx_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         digit;
    logic [12:0]        acc_x10;
    logic [12:0]        acc_x6;
    logic [12:0]        horner;
    logic               in_valid;

    always_comb begin
        in_valid = (bus.time_in[15:12] <= 4'd9) && (bus.time_in[11:8] <= 4'd9) &&
                   (bus.time_in[7:4]   <= 4'd5) && (bus.time_in[3:0]  <= 4'd9);
    end

    always_comb begin
        digit = 4'd0;
        case (idx_q)
            2'd3:    digit = tin_q[15:12];
            2'd2:    digit = tin_q[11:8];
            2'd1:    digit = tin_q[7:4];
            default: digit = tin_q[3:0];
        endcase
    end

    // Minute digits scale by 10, the sec-tens step by 6 (60 = 6*10), all shift-add.
    always_comb begin
        acc_x10 = (acc_q << 3) + (acc_q << 1);
        acc_x6  = (acc_q << 2) + (acc_q << 1);
        horner  = {9'd0, digit};
        case (idx_q)
            2'd3:    horner = {9'd0, digit};
            2'd2:    horner = acc_x10 + {9'd0, digit};
            2'd1:    horner = acc_x6 + {9'd0, digit};
            default: horner = acc_x10 + {9'd0, digit};
        endcase
    end

    always_comb begin
        state_d = state_q;
        tin_d   = tin_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    tin_d = bus.time_in;
                    if (!in_valid) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        ovf_d   = 1'b0;
                        count_d = '0;
                    end else begin
                        state_d = ST_CONV;
                        acc_d   = '0;
                        idx_d   = 2'd3;
                    end
                end
            end
            ST_CONV: begin
                acc_d = horner;
                if (idx_q == 2'd0) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                    if ({1'b0, horner} > MAX_CNT) begin
                        ovf_d   = 1'b1;
                        count_d = '1;
                    end else begin
                        ovf_d   = 1'b0;
                        count_d = horner[COUNT_W-1:0];
                    end
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tin_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tin_q   <= tin_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.count_out = count_q;
    assign bus.bcd_err   = err_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_time_to_count.sv
// tb/tb_time_to_count.sv - scoreboard bench for time_to_count with a seconds-arithmetic reference model
module tb_time_to_count;

    localparam int COUNT_W = 12;
    localparam int MAX_CNT = (1 << COUNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    typedef struct {
        int   cnt;
        logic err;
        logic ovf;
        int   t;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];

    time_to_count_if #(.COUNT_W(COUNT_W)) bus ();

    time_to_count #(.COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: total seconds straight from the four digits.
    function automatic exp_t model(input logic [15:0] v, input int now);
        exp_t e;
        int m1, m0, s1, s0, total;
        m1 = int'(v[15:12]);
        m0 = int'(v[11:8]);
        s1 = int'(v[7:4]);
        s0 = int'(v[3:0]);
        e.v = v;
        if (m1 > 9 || m0 > 9 || s1 > 5 || s0 > 9) begin
            e.cnt = 0; e.err = 1'b1; e.ovf = 1'b0; e.t = now + 1;
        end else begin
            total = m1 * 600 + m0 * 60 + s1 * 10 + s0;
            e.err = 1'b0;
            e.t   = now + 5;
            if (total > MAX_CNT) begin
                e.cnt = MAX_CNT; e.ovf = 1'b1;
            end else begin
                e.cnt = total; e.ovf = 1'b0;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("count_%h", e.v), int'(bus.count_out), e.cnt);
                check($sformatf("bcd_err_%h", e.v), int'(bus.bcd_err), int'(e.err));
                check($sformatf("ovf_%h", e.v), int'(bus.ovf), int'(e.ovf));
                check($sformatf("latency_%h", e.v), cyc, e.t);
                check("flag_combo", int'(bus.bcd_err & bus.ovf), 0);
            end
        end
    end

    // While busy, throw random start pulses and time_in values at the DUT; they must be ignored.
    task automatic wait_idle_noisy();
        int guard = 0;
        while (bus.busy && guard < 50) begin
            bus.start   = 1'($urandom % 2);
            bus.time_in = 16'($urandom);
            @(negedge clk);
            guard++;
        end
        if (bus.busy) check("idle_timeout", 1, 0);
        bus.start = 1'b0;
    endtask

    task automatic issue(input logic [15:0] v);
        wait_idle_noisy();
        bus.start   = 1'b1;
        bus.time_in = v;
        sb.push_back(model(v, cyc));
        @(negedge clk);
        bus.start   = 1'b0;
        bus.time_in = 16'($urandom);
    endtask

    logic [15:0] directed [12] = '{16'h0130, 16'h0545, 16'h2317, 16'h5959, 16'h0000,
                                   16'h6815, 16'h6816, 16'h9959, 16'h1260, 16'h0A00,
                                   16'h0001, 16'h0130};

    initial begin
        bus.start   = 1'b0;
        bus.time_in = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.done), 0);
        check("rst_count", int'(bus.count_out), 0);
        check("rst_err",   int'(bus.bcd_err), 0);
        check("rst_ovf",   int'(bus.ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (directed[i]) issue(directed[i]);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] v;
            if ($urandom % 3 == 0) v = 16'($urandom);
            else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            issue(v);
        end

        // start held high: a new conversion every 6 cycles
        wait_idle_noisy();
        bus.start   = 1'b1;
        bus.time_in = 16'h0545;
        for (int k = 0; k < 4; k++) begin
            int guard = 0;
            while (bus.busy && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (bus.busy) check("held_timeout", 1, 0);
            sb.push_back(model(16'h0545, cyc));
            @(negedge clk);
        end
        bus.start = 1'b0;

        // reset during CONV aborts with no done and clears the held result
        wait_idle_noisy();
        @(negedge clk);
        check("pre_abort_count", int'(bus.count_out), 345);
        bus.start   = 1'b1;
        bus.time_in = 16'h0130;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",  int'(bus.busy), 0);
        check("abort_done",  int'(bus.done), 0);
        check("abort_count", int'(bus.count_out), 0);
        check("abort_err",   int'(bus.bcd_err), 0);
        check("abort_ovf",   int'(bus.ovf), 0);
        repeat (6) @(negedge clk);
        issue(16'h0130);

        // reset and start on the same edge: stays idle
        wait_idle_noisy();
        @(negedge clk);
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.time_in = 16'h0200;
        @(negedge clk);
        check("rst_start_busy", int'(bus.busy), 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_busy2", int'(bus.busy), 0);
        check("rst_start_done",  int'(bus.done), 0);
        issue(16'h0001);

        for (int g = 0; g < 40 && sb.size() != 0; g++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/time_to_count.md
Name: time_to_count

Overview:
- Sequential converter from a packed BCD MM:SS value to a binary seconds count.
- It is the inverse of bcd_to_time, which drives the display.
- Used when the user keys in or loads a preset time: the BCD entry is validated, converted to seconds, and handed to the countdown counter.
- Single-shot start/busy/done handshake; one BCD digit is folded into the accumulator per cycle (Horner form).

Parameters:
- COUNT_W, 12: width of count_out in bits; legal range 7..13. 2^COUNT_W-1 is the largest representable count.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request conversion; sampled only when busy=0
- time_in  in  16  BCD MM:SS, packed as [15:12]=min tens, [11:8]=min units, [7:4]=sec tens, [3:0]=sec units
- busy  out  1  conversion in progress; start is ignored while high
- done  out  1  one-cycle pulse when count_out, bcd_err and ovf are updated
- count_out  out  COUNT_W  converted seconds; held until the next done
- bcd_err  out  1  last conversion rejected as malformed BCD; held until the next done
- ovf  out  1  last result exceeded 2^COUNT_W-1; held until the next done

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - busy=0, done=0, count_out=0, bcd_err=0, ovf=0.
  - State goes to IDLE; accumulator and digit index are cleared.
  - Reset overrides all other inputs, including start on the same edge.
- States: IDLE, CONV, DONE. busy=1 in CONV and DONE; done=1 only in DONE.
- IDLE, on start=1:
  - time_in is captured into an internal register; later changes to time_in are ignored.
  - The captured value is validated. It is invalid if any nibble is >9, or sec tens is >5.
  - Invalid: go to DONE with bcd_err<=1, ovf<=0, count_out<=0.
  - Valid: go to CONV with acc<=0, idx<=3.
- CONV: one digit per cycle, accumulator 13 bits wide (max 5999 fits).
  - idx3: acc = m1
  - idx2: acc = acc*10 + m0
  - idx1: acc = acc*6 + s1
  - idx0: acc = acc*10 + s0, then go to DONE
  - Multiplies are implemented as shift-add, e.g. x*10 = (x<<3)+(x<<1) and x*6 = (x<<2)+(x<<1).
- Entry to DONE from CONV, using the final acc:
  - If final acc > 2^COUNT_W-1: ovf<=1 and count_out saturates to all ones.
  - Otherwise: ovf<=0 and count_out<=acc[COUNT_W-1:0].
  - In both cases bcd_err<=0.
- DONE lasts exactly 1 cycle, then returns to IDLE. start is ignored in DONE.
- Latency, counted from the edge that samples start:
  - Valid input: done is high in the cycle following the 5th edge, i.e. the start edge plus 4 CONV edges.
  - Invalid input: done is high after 1 edge.
- Back-to-back: start may be reasserted in the cycle after done; the next conversion begins immediately.
- Boundary cases:
  - 00:00 produces 0 with no flags set.
  - 99:59 produces 5999, which gives ovf for COUNT_W<13.
  - With COUNT_W=12, 68:15=4095 is the largest non-overflowing input.
  - start held high continuously retriggers every 6 cycles (valid input); there is no edge detection.
- Reset mid-CONV aborts the conversion: no done pulse, and the previous count_out is lost (it resets to 0).
- done, bcd_err and ovf never assert together with anything other than these combinations:
  - done=1, bcd_err=1, ovf=0
  - done=1, bcd_err=0, ovf=0/1

Test Plan:
- Valid conversions: time_in=16'h0130, start pulse -> busy high for 5 cycles; done pulse with count_out=90, bcd_err=0, ovf=0. Repeat for 16'h0545 -> 345, 16'h2317 -> 1397, 16'h5959 -> 3599, 16'h0000 -> 0.
- Overflow, COUNT_W=12: 16'h6815 -> 4095, ovf=0. 16'h6816 -> count_out=4095, ovf=1. 16'h9959 -> count_out=4095, ovf=1.
- Malformed BCD: 16'h1260 (sec tens 6) and 16'h0A00 (nibble A) -> done 1 cycle after start, bcd_err=1, count_out=0. A following valid 16'h0001 clears bcd_err and gives count_out=1.
- Handshake:
  - Pulse start again during CONV and during DONE with different time_in -> ignored; the first result is produced.
  - Change time_in mid-conversion -> no effect on the result.
  - start held high -> a done pulse every 6 cycles.
- Reset: assert rst on the 3rd CONV cycle of 16'h0130 -> no done; all outputs 0 the next cycle. A new start then converts correctly. rst and start on the same edge -> stays in IDLE.
